mmio_responder: RTL

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/mmio_timer.sv | 76 +++++++
 rtl/mmio_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared register map, bit positions and write-strobe payload for the MMIO responder.
package mmio_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned OFF_W  = 4;

  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 8'hF0;

  localparam logic [OFF_W-1:0] OFF_PORT_OUT = 4'h0;
  localparam logic [OFF_W-1:0] OFF_PORT_IN  = 4'h1;
  localparam logic [OFF_W-1:0] OFF_TCNT     = 4'h2;
  localparam logic [OFF_W-1:0] OFF_TCMP     = 4'h3;
  localparam logic [OFF_W-1:0] OFF_TCTRL    = 4'h4;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 4'h5;

  localparam int unsigned TCTRL_EN_BIT      = 0;
  localparam int unsigned TCTRL_AUTOCLR_BIT = 1;
  localparam int unsigned STATUS_MATCH_BIT  = 0;

  // One-hot write strobes into the timer, decoded by the top.
  typedef struct packed {
    logic tcnt;
    logic tcmp;
    logic tctrl;
    logic status;
  } tmr_wr_t;

endpackage

// File: rtl/mmio_timer.sv
// Compare-match timer: TCNT/TCMP/TCTRL registers and the sticky MATCH flag.
// Only instantiated when MMIO_TIMER_EN is defined.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  tmr_wr_t           wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] tcnt,
  output logic [DATA_W-1:0] tcmp,
  output logic [DATA_W-1:0] tctrl,
  output logic              match
);

  logic [DATA_W-1:0] tcnt_q, tcnt_d;
  logic [DATA_W-1:0] tcmp_q;
  logic              en_q, autoclr_q;
  logic              match_q, match_d;
  logic              hit_c;

  assign hit_c = en_q && (tcnt_q == tcmp_q);

  // Processor write beats auto-clear, which beats increment.
  always_comb begin
    tcnt_d = tcnt_q;
    if (wr.tcnt) begin
      tcnt_d = wdata;
    end else if (hit_c && autoclr_q) begin
      tcnt_d = '0;
    end else if (en_q) begin
      tcnt_d = tcnt_q + DATA_W'(1);
    end
  end

  // A fresh match wins over a simultaneous write-1-to-clear.
  always_comb begin
    match_d = match_q;
    if (hit_c) begin
      match_d = 1'b1;
    end else if (wr.status && wdata[STATUS_MATCH_BIT]) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q    <= '0;
      tcmp_q    <= '0;
      en_q      <= 1'b0;
      autoclr_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      match_q <= match_d;
      if (wr.tcmp) begin
        tcmp_q <= wdata;
      end
      if (wr.tctrl) begin
        en_q      <= wdata[TCTRL_EN_BIT];
        autoclr_q <= wdata[TCTRL_AUTOCLR_BIT];
      end
    end
  end

  always_comb begin
    tctrl                    = '0;
    tctrl[TCTRL_EN_BIT]      = en_q;
    tctrl[TCTRL_AUTOCLR_BIT] = autoclr_q;
  end

  assign tcnt  = tcnt_q;
  assign tcmp  = tcmp_q;
  assign match = match_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder: RAM below IO_BASE, 16-byte I/O window at IO_BASE.
// Define MMIO_TIMER_EN to include the compare-match timer (offsets 0x2-0x5, timer_irq).
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_out,
  output logic              timer_irq
);

  localparam int unsigned RAM_DEPTH = 32'(IO_BASE);
  localparam int unsigned RAM_AW    = 32'($clog2(RAM_DEPTH));

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic [DATA_W-1:0] dout_q, rdata_c;
  logic [DATA_W-1:0] port_out_q;
  logic [DATA_W-1:0] sync1_q, sync2_q;
  logic              is_ram_c, is_io_c, io_wr_c;
  logic [OFF_W-1:0]  io_off_c;

  assign is_ram_c = (addr < IO_BASE);
  assign is_io_c  = (addr[ADDR_W-1:OFF_W] == IO_BASE[ADDR_W-1:OFF_W]);
  assign io_off_c = addr[OFF_W-1:0];
  assign io_wr_c  = we && is_io_c;

`ifdef MMIO_TIMER_EN
  tmr_wr_t           tmr_wr_c;
  logic [DATA_W-1:0] tcnt, tcmp, tctrl;
  logic              match;

  always_comb begin
    tmr_wr_c = '0;
    if (io_wr_c) begin
      case (io_off_c)
        OFF_TCNT:   tmr_wr_c.tcnt   = 1'b1;
        OFF_TCMP:   tmr_wr_c.tcmp   = 1'b1;
        OFF_TCTRL:  tmr_wr_c.tctrl  = 1'b1;
        OFF_STATUS: tmr_wr_c.status = 1'b1;
        default:    tmr_wr_c        = '0;
      endcase
    end
  end

  mmio_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .wr    (tmr_wr_c),
    .wdata (din),
    .tcnt  (tcnt),
    .tcmp  (tcmp),
    .tctrl (tctrl),
    .match (match)
  );

  assign timer_irq = match;
`else
  assign timer_irq = 1'b0;
`endif

  // Read mux sees pre-edge state, giving read-before-write on the same edge.
  always_comb begin
    rdata_c = '0;
    if (is_ram_c) begin
      rdata_c = ram_q[addr[RAM_AW-1:0]];
    end else if (is_io_c) begin
      case (io_off_c)
        OFF_PORT_OUT: rdata_c = port_out_q;
        OFF_PORT_IN:  rdata_c = sync2_q;
`ifdef MMIO_TIMER_EN
        OFF_TCNT:     rdata_c = tcnt;
        OFF_TCMP:     rdata_c = tcmp;
        OFF_TCTRL:    rdata_c = tctrl;
        OFF_STATUS:   rdata_c[STATUS_MATCH_BIT] = match;
`endif
        default:      rdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      port_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      dout_q  <= rdata_c;
      sync1_q <= port_in;
      sync2_q <= sync1_q;
      if (io_wr_c && (io_off_c == OFF_PORT_OUT)) begin
        port_out_q <= din;
      end
    end
  end

  // RAM contents deliberately survive reset; writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (we && is_ram_c && !rst) begin
      ram_q[addr[RAM_AW-1:0]] <= din;
    end
  end

  assign dout     = dout_q;
  assign port_out = port_out_q;

endmodule
